loadstore_unit: RTL and testbench

LOADSTORE_UNIT -- requirements
Module: loadstore_unit

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/load_extend.sv | 37 +++
 rtl/loadstore_unit.sv | 145 ++++++++++++++
 tb/tb_loadstore_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-access encodings and load/store FSM state type.
// Also imported by the instruction decoder so MemType values stay in one place.
package riscv_pkg;

    typedef enum logic [1:0] {
        MemWord    = 2'b00,
        MemByte    = 2'b01,
        MemHalf    = 2'b10,
        MemWordAlt = 2'b11
    } mem_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

    // Byte accesses can never be misaligned; type 11 behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] mtype, input logic [1:0] offset);
        logic w_mis;
        unique case (mem_type_e'(mtype))
            MemByte: w_mis = 1'b0;
            MemHalf: w_mis = offset[0];
            default: w_mis = (offset != 2'b00);
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_extend
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [1:0]            i_offset,
    input  logic [1:0]            i_type,
    input  logic                  i_zero_ext,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_fill;

    assign w_byte = i_word[{i_offset, 3'b000} +: 8];
    assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        w_fill = 1'b0;
        o_data = i_word;
        unique case (mem_type_e'(i_type))
            MemByte: begin
                w_fill = ~i_zero_ext & w_byte[7];
                o_data = {{(DATA_WIDTH - 8){w_fill}}, w_byte};
            end
            MemHalf: begin
                w_fill = ~i_zero_ext & w_half[15];
                o_data = {{(DATA_WIDTH - 16){w_fill}}, w_half};
            end
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/loadstore_unit.sv
// Load/store unit: one outstanding access, request/grant then rvalid handshake,
// lane steering for sub-word stores and extension for sub-word loads.
module loadstore_unit
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [1:0]            MemType_i,
    input  logic                  MemSign_i,
    input  logic [ADDR_WIDTH-1:0] Addr_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    output logic                  Stall_o,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    output logic                  Done_o,
    output logic                  Misalign_o,
    output logic                  MemReq_o,
    output logic                  MemWe_o,
    output logic [ADDR_WIDTH-1:0] MemAddr_o,
    output logic [DATA_WIDTH-1:0] MemWData_o,
    output logic [3:0]            MemBe_o,
    input  logic                  MemGnt_i,
    input  logic                  MemRValid_i,
    input  logic [DATA_WIDTH-1:0] MemRData_i
);

    lsu_state_e            r_state;
    lsu_state_e            w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_type;
    logic                  r_sign;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic                  r_misalign;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_req;
    logic                  w_misalign;
    logic [DATA_WIDTH-1:0] w_load;

    assign w_req      = MemRead_i | MemWrite_i;
    assign w_misalign = is_misaligned(MemType_i, Addr_i[1:0]);

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extend (
        .i_word     (MemRData_i),
        .i_offset   (r_addr[1:0]),
        .i_type     (r_type),
        .i_zero_ext (r_sign),
        .o_data     (w_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:  if (w_req) w_next = w_misalign ? StDone : StReq;
            StReq:   if (MemGnt_i) w_next = r_we ? StDone : StWait;
            StWait:  if (MemRValid_i) w_next = StDone;
            StDone:  w_next = StIdle;
            default: w_next = StIdle;
        endcase
    end

    // Write wins when both request lines are high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_type     <= '0;
            r_sign     <= 1'b0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (r_state == StIdle && w_req) begin
                r_addr     <= Addr_i;
                r_type     <= MemType_i;
                r_sign     <= MemSign_i;
                r_wdata    <= WriteData_i;
                r_we       <= MemWrite_i;
                r_misalign <= w_misalign;
                if (w_misalign) begin
                    r_rdata <= '0;
                end
            end
            if (r_state == StWait && MemRValid_i) begin
                r_rdata <= w_load;
            end
        end
    end

    always_comb begin
        Stall_o    = 1'b0;
        Done_o     = 1'b0;
        Misalign_o = 1'b0;
        MemReq_o   = 1'b0;
        MemWe_o    = 1'b0;
        MemBe_o    = 4'b0000;
        unique case (r_state)
            StIdle: Stall_o = w_req;
            StReq: begin
                Stall_o  = 1'b1;
                MemReq_o = 1'b1;
                MemWe_o  = r_we;
                unique case (mem_type_e'(r_type))
                    MemByte: MemBe_o = 4'b0001 << r_addr[1:0];
                    MemHalf: MemBe_o = 4'b0011 << {r_addr[1], 1'b0};
                    default: MemBe_o = 4'b1111;
                endcase
            end
            StWait: Stall_o = 1'b1;
            StDone: begin
                Done_o     = 1'b1;
                Misalign_o = r_misalign;
            end
            default: Stall_o = 1'b0;
        endcase
    end

    always_comb begin
        MemWData_o = r_wdata;
        unique case (mem_type_e'(r_type))
            MemByte: MemWData_o = {(DATA_WIDTH / 8){r_wdata[7:0]}};
            MemHalf: MemWData_o = {(DATA_WIDTH / 16){r_wdata[15:0]}};
            default: MemWData_o = r_wdata;
        endcase
    end

    assign MemAddr_o  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign ReadData_o = r_rdata;

endmodule

// File: tb/tb_loadstore_unit.sv
// Directed, table-driven bench for loadstore_unit with a responsive memory stub
// and hand-written sequences for grant back-pressure and reset mid-access.
module tb_loadstore_unit;

    logic        clk;
    logic        rst;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [1:0]  MemType_i;
    logic        MemSign_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic        Stall_o;
    logic [31:0] ReadData_o;
    logic        Done_o;
    logic        Misalign_o;
    logic        MemReq_o;
    logic        MemWe_o;
    logic [31:0] MemAddr_o;
    logic [31:0] MemWData_o;
    logic [3:0]  MemBe_o;
    logic        MemGnt_i;
    logic        MemRValid_i;
    logic [31:0] MemRData_i;

    loadstore_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .MemType_i   (MemType_i),
        .MemSign_i   (MemSign_i),
        .Addr_i      (Addr_i),
        .WriteData_i (WriteData_i),
        .Stall_o     (Stall_o),
        .ReadData_o  (ReadData_o),
        .Done_o      (Done_o),
        .Misalign_o  (Misalign_o),
        .MemReq_o    (MemReq_o),
        .MemWe_o     (MemWe_o),
        .MemAddr_o   (MemAddr_o),
        .MemWData_o  (MemWData_o),
        .MemBe_o     (MemBe_o),
        .MemGnt_i    (MemGnt_i),
        .MemRValid_i (MemRValid_i),
        .MemRData_i  (MemRData_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  mtype;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        logic        exp_req;
        logic        exp_we;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    int          n_checks;
    int          n_pass;
    logic [31:0] model_last;
    vec_t        vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        MemGnt_i    = 1'b0;
        MemRValid_i = 1'b0;
    endtask

    // Drives one access, plays memory with the vector's grant delay, checks the result.
    task automatic run_vec(input vec_t v);
        int          cyc;
        int          req_cnt;
        bit          saw_req;
        bit          done;
        logic [31:0] exp_rd;
        MemRead_i   = v.rd;
        MemWrite_i  = v.wr;
        MemType_i   = v.mtype;
        MemSign_i   = v.sign;
        Addr_i      = v.addr;
        WriteData_i = v.wdata;
        MemGnt_i    = 1'b0;
        MemRValid_i = 1'b0;
        #1;
        chk({v.name, "/stall_idle"}, 32'(Stall_o), 32'd1);
        tick();
        cyc     = 1;
        req_cnt = 0;
        saw_req = 0;
        done    = 0;
        while (!done && cyc < 30) begin
            if (Done_o) begin
                done = 1;
            end else begin
                MemGnt_i    = 1'b0;
                MemRValid_i = 1'b0;
                if (MemReq_o) begin
                    if (!saw_req) begin
                        chk({v.name, "/be"}, 32'(MemBe_o), 32'(v.exp_be));
                        chk({v.name, "/maddr"}, MemAddr_o, v.exp_maddr);
                        chk({v.name, "/mwdata"}, MemWData_o, v.exp_mwdata);
                        chk({v.name, "/we"}, 32'(MemWe_o), 32'(v.exp_we));
                    end
                    saw_req  = 1;
                    MemGnt_i = (req_cnt >= v.gnt_dly);
                    req_cnt++;
                end else if (Stall_o) begin
                    MemRValid_i = 1'b1;
                    MemRData_i  = v.rdata;
                end
                tick();
                cyc++;
            end
        end
        MemGnt_i    = 1'b0;
        MemRValid_i = 1'b0;
        chk({v.name, "/done_seen"}, 32'(done), 32'd1);
        chk({v.name, "/latency"}, 32'(cyc), 32'(v.exp_lat));
        chk({v.name, "/req_issued"}, 32'(saw_req), 32'(v.exp_req));
        chk({v.name, "/misalign"}, 32'(Misalign_o), 32'(v.exp_mis));
        chk({v.name, "/stall_done"}, 32'(Stall_o), 32'd0);
        exp_rd = (v.exp_we && !v.exp_mis) ? model_last : v.exp_rd;
        chk({v.name, "/rdata"}, ReadData_o, exp_rd);
        model_last  = exp_rd;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        tick();
        chk({v.name, "/done_pulse"}, 32'(Done_o), 32'd0);
        chk({v.name, "/rdata_hold"}, ReadData_o, exp_rd);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        model_last = 32'h0;
        //          name        rd wr  typ   s  addr          wdata         rdata         g  rq we mi be       maddr         mwdata        rd            lat
        vecs[0]  = '{"sw",      0, 1, 2'b00, 0, 32'h104, 32'hDEADBEEF, 32'h0,        0, 1, 1, 0, 4'b1111, 32'h104, 32'hDEADBEEF, 32'h0,        2};
        vecs[1]  = '{"lb",      1, 0, 2'b01, 0, 32'h103, 32'h0,        32'h80FFFFFF, 0, 1, 0, 0, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80, 3};
        vecs[2]  = '{"lhu",     1, 0, 2'b10, 1, 32'h102, 32'h0,        32'h8001AAAA, 0, 1, 0, 0, 4'b1100, 32'h100, 32'h0,        32'h00008001, 3};
        vecs[3]  = '{"sh_mis",  0, 1, 2'b10, 0, 32'h101, 32'h0000BEEF, 32'h0,        0, 0, 1, 1, 4'b0000, 32'h100, 32'h0,        32'h0,        1};
        vecs[4]  = '{"lw_gnt1", 1, 0, 2'b00, 0, 32'h200, 32'h0,        32'h12345678, 1, 1, 0, 0, 4'b1111, 32'h200, 32'h0,        32'h12345678, 4};
        vecs[5]  = '{"lbu",     1, 0, 2'b01, 1, 32'h101, 32'h0,        32'h0000F100, 0, 1, 0, 0, 4'b0010, 32'h100, 32'h0,        32'h000000F1, 3};
        vecs[6]  = '{"lh",      1, 0, 2'b10, 0, 32'h100, 32'h0,        32'h00008765, 0, 1, 0, 0, 4'b0011, 32'h100, 32'h0,        32'hFFFF8765, 3};
        vecs[7]  = '{"sb",      0, 1, 2'b01, 0, 32'h13,  32'h000000A5, 32'h0,        0, 1, 1, 0, 4'b1000, 32'h10,  32'hA5A5A5A5, 32'h0,        2};
        vecs[8]  = '{"sh",      0, 1, 2'b10, 0, 32'h22,  32'h1234BEEF, 32'h0,        0, 1, 1, 0, 4'b1100, 32'h20,  32'hBEEFBEEF, 32'h0,        2};
        vecs[9]  = '{"lw_mis",  1, 0, 2'b00, 0, 32'h2,   32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,   32'h0,        32'h0,        1};
        vecs[10] = '{"t11_mis", 1, 0, 2'b11, 0, 32'h45,  32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h44,  32'h0,        32'h0,        1};
        vecs[11] = '{"lb_pos",  1, 0, 2'b01, 0, 32'h100, 32'h0,        32'h0000007F, 0, 1, 0, 0, 4'b0001, 32'h100, 32'h0,        32'h0000007F, 3};
        vecs[12] = '{"rd_wr",   1, 1, 2'b00, 0, 32'h40,  32'hCAFEF00D, 32'hFFFFFFFF, 0, 1, 1, 0, 4'b1111, 32'h40,  32'hCAFEF00D, 32'h0,        2};
        vecs[13] = '{"t11_rd",  1, 0, 2'b11, 0, 32'h44,  32'h0,        32'h55AA55AA, 2, 1, 0, 0, 4'b1111, 32'h44,  32'h0,        32'h55AA55AA, 5};
        vecs[14] = '{"lhu_hi",  1, 0, 2'b10, 1, 32'h306, 32'h0,        32'hC3C30000, 0, 1, 0, 0, 4'b1100, 32'h304, 32'h0,        32'h0000C3C3, 3};

        idle_inputs();
        MemType_i   = 2'b00;
        MemSign_i   = 1'b0;
        Addr_i      = 32'h0;
        WriteData_i = 32'h0;
        MemRData_i  = 32'h0;
        rst         = 1'b1;
        tick();
        tick();
        chk("reset/stall", 32'(Stall_o), 32'd0);
        chk("reset/done", 32'(Done_o), 32'd0);
        chk("reset/misalign", 32'(Misalign_o), 32'd0);
        chk("reset/req_we", {30'd0, MemReq_o, MemWe_o}, 32'd0);
        chk("reset/rdata", ReadData_o, 32'h0);
        chk("reset/maddr", MemAddr_o, 32'h0);
        chk("reset/mwdata", MemWData_o, 32'h0);
        chk("reset/be", 32'(MemBe_o), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i]);
        end

        // SB 0x5A to 0x102 with the grant withheld for three REQ cycles.
        MemWrite_i  = 1'b1;
        MemRead_i   = 1'b0;
        MemType_i   = 2'b01;
        MemSign_i   = 1'b0;
        Addr_i      = 32'h102;
        WriteData_i = 32'h0000005A;
        tick();
        for (int k = 0; k < 3; k++) begin
            MemGnt_i = 1'b0;
            chk($sformatf("sb_hold%0d/req", k), 32'(MemReq_o), 32'd1);
            chk($sformatf("sb_hold%0d/stall", k), 32'(Stall_o), 32'd1);
            chk($sformatf("sb_hold%0d/be", k), 32'(MemBe_o), 32'b0100);
            chk($sformatf("sb_hold%0d/wdata", k), MemWData_o, 32'h5A5A5A5A);
            tick();
        end
        chk("sb_hold/req_at_grant", 32'(MemReq_o), 32'd1);
        MemGnt_i = 1'b1;
        tick();
        MemGnt_i = 1'b0;
        chk("sb_hold/done", 32'(Done_o), 32'd1);
        chk("sb_hold/rdata_kept", ReadData_o, model_last);
        MemWrite_i = 1'b0;
        tick();

        // LW abandoned by reset while waiting for read data; late rvalid is ignored.
        MemRead_i = 1'b1;
        MemType_i = 2'b00;
        Addr_i    = 32'h300;
        tick();
        chk("rst_wait/req", 32'(MemReq_o), 32'd1);
        MemGnt_i = 1'b1;
        tick();
        MemGnt_i = 1'b0;
        chk("rst_wait/in_wait", {30'd0, Stall_o, MemReq_o}, 32'b10);
        rst       = 1'b1;
        MemRead_i = 1'b0;
        tick();
        rst         = 1'b0;
        MemRValid_i = 1'b1;
        MemRData_i  = 32'h11112222;
        tick();
        MemRValid_i = 1'b0;
        chk("rst_wait/done", 32'(Done_o), 32'd0);
        chk("rst_wait/rdata", ReadData_o, 32'h0);
        chk("rst_wait/stall_req", {30'd0, Stall_o, MemReq_o}, 32'd0);
        tick();
        chk("rst_wait/done_later", 32'(Done_o), 32'd0);
        model_last = 32'h0;
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
